temp_spi_reader: RTL and testbench
==================================

TEMP_SPI_READER -- requirements
Module: temp_spi_reader

Interface
- REQ-001: Parameter CLK_DIV, default 25; clk cycles per SCLK half-period, legal range 4..255.
- REQ-002: Parameter SAMPLE_PERIOD, default 50000000; clk cycles between automatic reads (1 s at 50 MHz).
- REQ-003: clk  input  1  single system clock; all state rising-edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: start  input  1  one-cycle request for an immediate read.
- REQ-006: miso  input  1  serial data from the sensor, asynchronous to clk.
- REQ-007: sclk  output  1  SPI clock, mode 0 (idle low).
- REQ-008: cs_n  output  1  sensor chip select, active low.
- REQ-009: temperatura  output  9  last good reading, sign-magnitude: bit 8 sign (1 = negative), bits 7:0 magnitude in integer degC.
- REQ-010: valid  output  1  one-cycle pulse when temperatura updates.
- REQ-011: err  output  1  level; high after a bad frame, cleared by the next good frame.
- REQ-012: busy  output  1  high from leaving IDLE until return to IDLE.

Function
- REQ-013: miso SHALL pass through a 2-flop synchronizer before use.
- REQ-014: The period counter SHALL count 0..SAMPLE_PERIOD-1, wrap to 0, and issue one tick at wrap; it SHALL run continuously, including while busy.
- REQ-015: A read request is a tick or start; a request while busy SHALL be dropped, with no queueing.
- REQ-016: FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
- REQ-017: IDLE -> SETUP on a request; cs_n SHALL go low in the same clk edge.
- REQ-018: SETUP SHALL last CLK_DIV cycles with sclk low, then go to SHIFT.
- REQ-019: SHIFT SHALL generate exactly 16 SCLK periods: CLK_DIV cycles low, then CLK_DIV cycles high.
- REQ-020: On the last clk cycle of each SCLK high phase, the synchronized miso SHALL be shifted into a 16-bit register, MSB first.
- REQ-021: After the 16th high phase, sclk SHALL return low and the FSM SHALL go to HOLD.
- REQ-022: HOLD SHALL keep cs_n low for CLK_DIV cycles, then raise cs_n and go to DONE.
- REQ-023: DONE SHALL last 1 cycle, then go to IDLE.
- REQ-024: Frame decode: raw = frame[15:7] is a 9-bit two's complement integer degC; frame[6:0] is ignored.
- REQ-025: Conversion: raw >= 0 gives sign 0, magnitude raw[7:0].
- REQ-026: Conversion: -255 <= raw < 0 gives sign 1, magnitude -raw.
- REQ-027: Conversion: raw = -256 SHALL saturate to sign 1, magnitude 255.
- REQ-028: Bad frame = 16'hFFFF (absent sensor) or 16'h0000 (stuck low).
- REQ-029: In DONE with a bad frame: err <= 1; temperatura and valid unchanged.
- REQ-030: In DONE with a good frame: temperatura updates, err <= 0, and valid pulses that cycle.
- REQ-031: Latency from request to valid SHALL be (34*CLK_DIV + 2) clk cycles.
- REQ-032: start and tick in the same cycle SHALL start one read only.

Reset
- REQ-033: While rst is high: state = IDLE, period counter = 0, shift register = 0, temperatura = 0, valid = 0, err = 0, busy = 0, sclk = 0, cs_n = 1.
- REQ-034: Reset asserted mid-transfer SHALL abort immediately (cs_n high asynchronously) with no valid pulse.
- REQ-035: The first automatic tick SHALL occur SAMPLE_PERIOD cycles after reset release.

Verification
- REQ-036: CLK_DIV=4, start, sensor sends 16'h0C80 (raw 25) -> 16 sclk periods, valid at cycle 138, temperatura = 9'h019, err = 0.
- REQ-037: Sensor sends 16'hF380 (raw -25) -> temperatura = 9'h119; sensor sends 16'h8000 (raw -256) -> temperatura = 9'h1FF.
- REQ-038: Good read 25, then 16'hFFFF -> err = 1, no valid pulse, temperatura stays 9'h019; next good frame clears err.
- REQ-039: SAMPLE_PERIOD=200 -> reads start at cycles 200, 400, 600; start at cycle 210 (busy) is dropped; start and tick together give one frame.
- REQ-040: rst pulsed at the 8th SCLK -> cs_n = 1, sclk = 0, busy = 0 immediately; no valid; outputs at reset values.

Source files
------------

// File: rtl/temp_spi_reader.sv
// SPI mode-0 reader for a 16-bit temperature sensor: periodic or on-demand
// frames, decoded from 9-bit two's complement into sign-magnitude degC.
module temp_spi_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miso,
  output logic       sclk,
  output logic       cs_n,
  output logic [8:0] temperatura,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0]  LP_DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [31:0] LP_PERIOD_LAST = 32'(SAMPLE_PERIOD - 1);

  // -256 has no 8-bit magnitude, so it saturates to -255.
  function automatic logic [8:0] f_to_sign_mag(input logic [8:0] raw);
    logic [8:0] neg;
    logic [8:0] res;
    neg = ~raw + 9'd1;
    if (!raw[8]) begin
      res = {1'b0, raw[7:0]};
    end else if (raw == 9'h100) begin
      res = 9'h1FF;
    end else begin
      res = {1'b1, neg[7:0]};
    end
    return res;
  endfunction

  state_t      r_state;
  state_t      w_state_nx;
  logic [7:0]  r_cnt;
  logic        r_half;
  logic        w_half_nx;
  logic [3:0]  r_bit;
  logic [15:0] r_shift;
  logic [31:0] r_period;
  logic        r_miso_meta;
  logic        r_miso_sync;
  logic        r_cs_n;
  logic        r_busy;
  logic        r_valid;
  logic        r_err;
  logic [8:0]  r_temp;

  logic w_tick;
  logic w_req;
  logic w_cnt_last;
  logic w_in_frame_nx;
  logic w_bad;

  assign w_tick        = (r_period == LP_PERIOD_LAST);
  assign w_req         = start | w_tick;
  assign w_cnt_last    = (r_cnt == LP_DIV_LAST);
  assign w_in_frame_nx = (w_state_nx == S_SETUP) || (w_state_nx == S_SHIFT) ||
                         (w_state_nx == S_HOLD);
  assign w_bad         = (r_shift == 16'hFFFF) || (r_shift == 16'h0000);

  // Next-state and next SCLK phase.
  always_comb begin
    w_state_nx = r_state;
    w_half_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_state_nx = S_SETUP;
        else       w_state_nx = S_IDLE;
      end
      S_SETUP: begin
        if (w_cnt_last) w_state_nx = S_SHIFT;
        else            w_state_nx = S_SETUP;
      end
      S_SHIFT: begin
        w_half_nx = w_cnt_last ? ~r_half : r_half;
        if (w_cnt_last && r_half && (r_bit == 4'd15)) w_state_nx = S_HOLD;
        else                                           w_state_nx = S_SHIFT;
      end
      S_HOLD: begin
        if (w_cnt_last) w_state_nx = S_DONE;
        else            w_state_nx = S_HOLD;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, timing counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_half      <= 1'b0;
      r_bit       <= 4'd0;
      r_shift     <= 16'd0;
      r_period    <= 32'd0;
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
      r_cs_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_temp      <= 9'd0;
    end else begin
      r_miso_meta <= miso;
      r_miso_sync <= r_miso_meta;
      r_period    <= w_tick ? 32'd0 : r_period + 32'd1;
      r_state     <= w_state_nx;
      r_half      <= w_half_nx;
      r_cs_n      <= ~w_in_frame_nx;
      r_busy      <= (w_state_nx != S_IDLE);

      if (((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD)) &&
          !w_cnt_last) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'd0;
      end

      // Sample on the last clk of each high phase, i.e. just before SCLK falls.
      if ((r_state == S_SHIFT) && r_half && w_cnt_last) begin
        r_shift <= {r_shift[14:0], r_miso_sync};
        r_bit   <= r_bit + 4'd1;
      end else if (r_state != S_SHIFT) begin
        r_bit   <= 4'd0;
      end else begin
        r_bit   <= r_bit;
      end

      if (r_state == S_DONE) begin
        if (w_bad) begin
          r_err   <= 1'b1;
          r_valid <= 1'b0;
        end else begin
          r_err   <= 1'b0;
          r_valid <= 1'b1;
          r_temp  <= f_to_sign_mag(r_shift[15:7]);
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign sclk        = r_half;
  assign cs_n        = r_cs_n;
  assign busy        = r_busy;
  assign valid       = r_valid;
  assign err         = r_err;
  assign temperatura = r_temp;

endmodule

// File: tb/tb_temp_spi_reader.sv
// Directed bench: dut_a (CLK_DIV=4, no automatic ticks) runs a frame table;
// dut_b (SAMPLE_PERIOD=200) exercises periodic reads and request dropping.
module tb_temp_spi_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, start_a = 1'b0, miso_a, sclk_a, cs_n_a, valid_a, err_a, busy_a;
  logic [8:0] temp_a;
  logic       rst_b = 1'b1, start_b = 1'b0, miso_b, sclk_b, cs_n_b, valid_b, err_b, busy_b;
  logic [8:0] temp_b;

  temp_spi_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(100000)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .miso(miso_a), .sclk(sclk_a),
    .cs_n(cs_n_a), .temperatura(temp_a), .valid(valid_a), .err(err_a), .busy(busy_a)
  );

  temp_spi_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(200)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .miso(miso_b), .sclk(sclk_b),
    .cs_n(cs_n_b), .temperatura(temp_b), .valid(valid_b), .err(err_b), .busy(busy_b)
  );

  // Sensor models: MSB presented when cs_n falls, next bit after each SCLK fall.
  logic [15:0] frame_a = 16'h0000;
  logic [15:0] frame_b = 16'h0C80;
  logic [4:0]  falls_a = 5'd0;
  logic [4:0]  falls_b = 5'd0;
  logic [3:0]  idx_a, idx_b;

  always @(negedge sclk_a or posedge cs_n_a)
    if (cs_n_a) falls_a <= 5'd0;
    else if (falls_a != 5'd31) falls_a <= falls_a + 5'd1;

  always @(negedge sclk_b or posedge cs_n_b)
    if (cs_n_b) falls_b <= 5'd0;
    else if (falls_b != 5'd31) falls_b <= falls_b + 5'd1;

  assign idx_a  = 4'd15 - falls_a[3:0];
  assign idx_b  = 4'd15 - falls_b[3:0];
  assign miso_a = (falls_a < 5'd16) ? frame_a[idx_a] : 1'b0;
  assign miso_b = (falls_b < 5'd16) ? frame_b[idx_b] : 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [8:0]  exp_temp;
    logic        exp_err;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [13];

  // Run one start-triggered frame on dut_a and observe it over a fixed window.
  task automatic run_frame(input logic [15:0] frame, output int vcnt, output int lat,
                           output int rises, output logic cs_ok, output logic idle_end);
    logic prev_sclk;
    frame_a = frame;
    vcnt = 0; lat = 0; rises = 0; cs_ok = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    prev_sclk = sclk_a;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (n == 1) cs_ok = (cs_n_a == 1'b0) && (busy_a == 1'b1);
      if (sclk_a && !prev_sclk) rises++;
      prev_sclk = sclk_a;
      if (valid_a) begin
        vcnt++;
        if (lat == 0) lat = n;
      end
    end
    idle_end = !busy_a && cs_n_a && !sclk_a;
  endtask

  initial begin
    int vcnt, lat, rises;
    logic cs_ok, idle_end;
    int falls_seen;
    int fall_at [4];
    int vb_cnt;
    logic prev_cs;
    logic prev_sclk;
    int waited;

    vecs[0]  = '{16'h0C80, 9'h019, 1'b0, 1'b1};
    vecs[1]  = '{16'hF380, 9'h119, 1'b0, 1'b1};
    vecs[2]  = '{16'h8000, 9'h1FF, 1'b0, 1'b1};
    vecs[3]  = '{16'hFFFF, 9'h1FF, 1'b1, 1'b0};
    vecs[4]  = '{16'h0C80, 9'h019, 1'b0, 1'b1};
    vecs[5]  = '{16'hFFFF, 9'h019, 1'b1, 1'b0};
    vecs[6]  = '{16'h0000, 9'h019, 1'b1, 1'b0};
    vecs[7]  = '{16'h0C80, 9'h019, 1'b0, 1'b1};
    vecs[8]  = '{16'h7F80, 9'h0FF, 1'b0, 1'b1};
    vecs[9]  = '{16'h807F, 9'h1FF, 1'b0, 1'b1};
    vecs[10] = '{16'hFF80, 9'h101, 1'b0, 1'b1};
    vecs[11] = '{16'h007F, 9'h000, 1'b0, 1'b1};
    vecs[12] = '{16'h0080, 9'h001, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_temp",  32'(temp_a), 32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_err",   32'(err_a), 32'h0);
    check("rst_busy",  32'(busy_a), 32'h0);
    check("rst_sclk",  32'(sclk_a), 32'h0);
    check("rst_cs_n",  32'(cs_n_a), 32'h1);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_frame(vecs[i].frame, vcnt, lat, rises, cs_ok, idle_end);
      check($sformatf("v%0d_temp", i),   32'(temp_a), 32'(vecs[i].exp_temp));
      check($sformatf("v%0d_err", i),    32'(err_a), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_vcnt", i),   32'(vcnt), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_lat", i),    32'(lat), vecs[i].exp_valid ? 32'd138 : 32'd0);
      check($sformatf("v%0d_sclks", i),  32'(rises), 32'd16);
      check($sformatf("v%0d_cs_low", i), 32'(cs_ok), 32'h1);
      check($sformatf("v%0d_idle", i),   32'(idle_end), 32'h1);
    end

    // Abort on reset at the 8th SCLK rising edge.
    frame_a = 16'h0C80;
    @(negedge clk);
    start_a = 1'b1;
    rises = 0;
    prev_sclk = sclk_a;
    waited = 0;
    while (rises < 8 && waited < 100) begin
      @(negedge clk);
      start_a = 1'b0;
      waited++;
      if (sclk_a && !prev_sclk) rises++;
      prev_sclk = sclk_a;
    end
    check("abort_reach_8th_sclk", 32'(rises), 32'd8);
    rst_a = 1'b1;
    #1;
    check("abort_cs_n",  32'(cs_n_a), 32'h1);
    check("abort_sclk",  32'(sclk_a), 32'h0);
    check("abort_busy",  32'(busy_a), 32'h0);
    check("abort_temp",  32'(temp_a), 32'h0);
    check("abort_err",   32'(err_a), 32'h0);
    check("abort_valid", 32'(valid_a), 32'h0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    vcnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (valid_a) vcnt++;
    end
    check("abort_no_valid", 32'(vcnt), 32'd0);
    check("abort_stay_idle", 32'(busy_a), 32'h0);

    // Periodic reads, a dropped start while busy, and start coinciding with a tick.
    falls_seen = 0;
    vb_cnt = 0;
    for (int j = 0; j < 4; j++) fall_at[j] = 0;
    @(negedge clk);
    rst_b = 1'b0;
    prev_cs = cs_n_b;
    for (int k = 1; k <= 760; k++) begin
      @(negedge clk);
      if (prev_cs && !cs_n_b) begin
        if (falls_seen < 4) fall_at[falls_seen] = k;
        falls_seen++;
      end
      prev_cs = cs_n_b;
      if (valid_b) vb_cnt++;
      start_b = (k == 210) || (k == 399);
    end
    start_b = 1'b0;
    check("per_frames",  32'(falls_seen), 32'd3);
    check("per_first",   32'(fall_at[0]), 32'd200);
    check("per_second",  32'(fall_at[1]), 32'd400);
    check("per_third",   32'(fall_at[2]), 32'd600);
    check("per_valids",  32'(vb_cnt), 32'd3);
    check("per_temp",    32'(temp_b), 32'h019);
    check("per_err",     32'(err_b), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
